fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 5-stage RV64 pipeline; the producer of decode's IF/ID inputs.
//  - Holds the PC and issues one outstanding request at a time to instruction memory.
//  - Loads the IF/ID register (InstrD/PCD/PCPlus4D/ValidD).
//  - Obeys decode's PCWriteF/IF_IDWriteF/IF_IDFlushF and branch/jump redirect PCSF/PCTargetD.
// PARAMETERS
//  XLEN      64     PC / address width
//  RESET_PC  64'h0  PC value after reset
// PORTS
//  clk         in   1     single clock, rising edge
//  rst         in   1     asynchronous, active-low reset
//  PCWriteF    in   1     0 = hold PC (load-use stall from decode)
//  IF_IDWriteF in   1     0 = hold IF/ID contents
//  IF_IDFlushF in   1     1 = IF/ID loads bubble next edge
//  PCSF        in   1     1 = redirect PC to PCTargetD
//  PCTargetD   in   XLEN  redirect target
//  ImemAddrF   out  XLEN  fetch address (= PC)
//  ImemReqF    out  1     request strobe; memory accepts unconditionally
//  ImemRdataF  in   32    instruction data, valid with ImemValidF
//  ImemValidF  in   1     response strobe, >=1 cycle after request
//  InstrD      out  32    IF/ID instruction
//  PCD         out  XLEN  IF/ID PC
//  PCPlus4D    out  XLEN  IF/ID PC+4
//  ValidD      out  1     1 = InstrD is real, 0 = bubble
// BEHAVIOUR
//  Reset (rst=0, async):
//  - PC=RESET_PC, state=S_REQ, InstrD=32'h00000013 (NOP), PCD=0, PCPlus4D=0, ValidD=0, hold buffer empty.
//  FSM:
//  - S_REQ: ImemReqF=1, ImemAddrF=PC -> S_WAIT.
//  - S_WAIT: ImemReqF=0; waits for ImemValidF.
//  - S_HOLD: response parked in 1-entry hold buffer during stall.
//  - S_DROP: in-flight response is discarded on arrival -> S_REQ.
//  Delivery (response arrives in S_WAIT, or hold buffer in S_HOLD):
//  - PCWriteF=1 and IF_IDWriteF=1: IF/ID <= {instr, PC, PC+4, 1}; PC <= PC+4; -> S_REQ.
//  - Otherwise: park in hold buffer; -> S_HOLD. ImemReqF stays 0 until delivered.
//  Priority, highest first:
//  - PCSF: PC <= PCTargetD; any same-cycle response or hold contents discarded, never written to IF/ID.
//    - Response arriving that cycle -> S_REQ.
//    - Response still outstanding -> S_DROP.
//  - IF_IDFlushF: IF/ID <= NOP, ValidD=0, regardless of IF_IDWriteF.
//  - IF_IDWriteF=0: IF/ID holds.
//  - IF_IDWriteF=1 with no delivery this cycle: IF/ID <= NOP bubble, ValidD=0.
//  Arithmetic and timing:
//  - PC+4 is XLEN-bit modulo; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
//  - PCTargetD[1:0] ignored (forced 0).
//  - Best-case throughput: 1 instr per 2 cycles (REQ+WAIT with 1-cycle memory).
//  - Latency: address issue to ValidD=1 is memory latency +1 edge.
//  - Reset mid-request: outstanding response is ignored; the memory model is reset by the same rst.
// CONFIGURATION
//  `FETCH_PERF_CNT_EN defined:
//  - Adds outputs FetchCntF[31:0] (instrs written to IF/ID with ValidD=1) and StallCntF[31:0] (cycles in S_HOLD).
//  - Both reset to 0 and wrap at 2^32.
//  Undefined: no counters, no extra ports.
// STRUCTURE
//  Shared package riscv_pkg:
//  - NOP_INSTR = 32'h00000013.
//  - fetch state encoding S_REQ/S_WAIT/S_HOLD/S_DROP (2 bits).
//  - XLEN default.
//  Sub-module if_id_reg: flush/enable/bubble register for {InstrD,PCD,PCPlus4D,ValidD}.
//  FSM, PC and hold buffer stay in fetch_stage.
// TESTING
//  1. Reset with RESET_PC=0, 1-cycle memory: ImemAddrF 0,4,8 on successive REQ cycles.
//     InstrD matches memory; PCD=0, PCPlus4D=4, ValidD=1.
//  2. Stall: memory returns instr at PC=8 while PCWriteF=IF_IDWriteF=0 for 3 cycles.
//     IF/ID holds prior instr; state S_HOLD; no new request.
//     Release: InstrD=mem[8], PCD=8, next ImemAddrF=12.
//  3. Redirect in S_WAIT: PCSF=1, PCTargetD=64'h100 (3-cycle memory).
//     Old response dropped; next ImemAddrF=64'h100; ValidD stays 0 until mem[0x100] is delivered.
//  4. IF_IDFlushF=1 with IF_IDWriteF=0: next edge InstrD=32'h00000013, ValidD=0.
//  5. PC=64'hFFFF_FFFF_FFFF_FFFC: PCPlus4D=0; next ImemAddrF=0.
//  6. Assert rst mid-S_WAIT: all outputs return to reset values immediately, without a clock edge.
//     With `FETCH_PERF_CNT_EN: FetchCntF=3 after tests 1's three fetches.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV64 pipeline constants and fetch FSM state encoding
package riscv_pkg;

  localparam int XLEN = 64;

  // addi x0, x0, 0: the canonical bubble instruction
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetchStateT;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with flush, write-enable and bubble insertion
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            enable,
  input  logic            load,
  input  logic [31:0]     instrIn,
  input  logic [XLEN-1:0] pcIn,
  input  logic [XLEN-1:0] pcPlus4In,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  // Flush beats hold; an enabled register with nothing to load takes a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (flush || (enable && !load)) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (enable) begin
      InstrD   <= instrIn;
      PCD      <= pcIn;
      PCPlus4D <= pcPlus4In;
      ValidD   <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV64 IF stage: PC, single-outstanding imem FSM, hold buffer; FETCH_PERF_CNT_EN adds counters
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCWriteF,
  input  logic            IF_IDWriteF,
  input  logic            IF_IDFlushF,
  input  logic            PCSF,
  input  logic [XLEN-1:0] PCTargetD,
  output logic [XLEN-1:0] ImemAddrF,
  output logic            ImemReqF,
  input  logic [31:0]     ImemRdataF,
  input  logic            ImemValidF,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     FetchCntF,
  output logic [31:0]     StallCntF
`endif
);

  fetchStateT      state, stateNext;
  logic [XLEN-1:0] pc, pcNext, pcPlus4, pcTarget;
  logic [31:0]     holdInstr, holdNext, deliverInstr;
  logic            respNow, haveInstr, deliver;

  assign ImemAddrF = pc;
  assign pcPlus4   = pc + XLEN'(4);
  // Targets are always word aligned; the low two bits from decode are dropped
  assign pcTarget  = PCTargetD & ~XLEN'(3);

  assign respNow      = (state == S_WAIT) && ImemValidF;
  assign haveInstr    = respNow || (state == S_HOLD);
  assign deliverInstr = (state == S_HOLD) ? holdInstr : ImemRdataF;
  // A flush would overwrite the IF/ID slot, so the instruction is parked rather than lost
  assign deliver      = haveInstr && !PCSF && !IF_IDFlushF && PCWriteF && IF_IDWriteF;

  // Next-state, next-PC and hold-buffer capture; redirect overrides normal sequencing
  always_comb begin
    stateNext = state;
    pcNext    = pc;
    holdNext  = holdInstr;
    ImemReqF  = 1'b0;

    case (state)
      S_REQ: begin
        ImemReqF  = 1'b1;
        stateNext = S_WAIT;
      end
      S_WAIT: begin
        if (ImemValidF) begin
          stateNext = deliver ? S_REQ : S_HOLD;
        end
      end
      S_HOLD: begin
        if (deliver) begin
          stateNext = S_REQ;
        end
      end
      S_DROP: begin
        if (ImemValidF) begin
          stateNext = S_REQ;
        end
      end
      default: stateNext = S_REQ;
    endcase

    if (respNow && !deliver) begin
      holdNext = ImemRdataF;
    end
    if (deliver) begin
      pcNext = pcPlus4;
    end

    if (PCSF) begin
      pcNext = pcTarget;
      case (state)
        // The request issued this cycle is already accepted by memory
        S_REQ:          stateNext = S_DROP;
        S_WAIT, S_DROP: stateNext = ImemValidF ? S_REQ : S_DROP;
        default:        stateNext = S_REQ;
      endcase
    end
  end

  // FSM state, PC and hold buffer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      holdInstr <= NOP_INSTR;
    end else begin
      state     <= stateNext;
      pc        <= pcNext;
      holdInstr <= holdNext;
    end
  end

  if_id_reg #(.XLEN(XLEN)) ifIdReg (
    .clk      (clk),
    .rst      (rst),
    .flush    (IF_IDFlushF),
    .enable   (IF_IDWriteF),
    .load     (deliver),
    .instrIn  (deliverInstr),
    .pcIn     (pc),
    .pcPlus4In(pcPlus4),
    .InstrD   (InstrD),
    .PCD      (PCD),
    .PCPlus4D (PCPlus4D),
    .ValidD   (ValidD)
  );

`ifdef FETCH_PERF_CNT_EN
  // Delivered-instruction and hold-cycle counters, both free-running with wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      FetchCntF <= '0;
      StallCntF <= '0;
    end else begin
      if (deliver) begin
        FetchCntF <= FetchCntF + 32'd1;
      end
      if (state == S_HOLD) begin
        StallCntF <= StallCntF + 32'd1;
      end
    end
  end
`endif

endmodule
